// File: rtl/vend_dispenser.sv
`default_nettype none
// ============================================================================
// Module   : vend_dispenser
// Brief    : Queues vending sales and drives soda/dime/nickel actuators one
//            at a time with a done handshake, inter-actuation gaps and timeout.
// Revision : 1.0 - initial release
// ============================================================================
module vend_dispenser #(
    parameter int DEPTH      = 4,
    parameter int GAP_CYCLES = 2,
    parameter int TIMEOUT    = 1000
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_soda,
    input  logic [2:0] i_change,
    input  logic       i_done,
    output logic       o_soda_drop,
    output logic       o_dime_eject,
    output logic       o_nickel_eject,
    output logic       o_busy,
    output logic       o_full,
    output logic       o_err,
    output logic       o_fault
);

    localparam int c_aw      = $clog2(DEPTH);
    localparam int c_cnt_max = (TIMEOUT > GAP_CYCLES) ? TIMEOUT : GAP_CYCLES;
    localparam int c_cw      = $clog2(c_cnt_max + 1);

    localparam logic [c_aw:0]   c_depth        = (c_aw + 1)'(DEPTH);
    localparam logic [c_cw-1:0] c_timeout_last = c_cw'(TIMEOUT - 1);
    localparam logic [c_cw-1:0] c_gap_last     = c_cw'(GAP_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LOAD   = 3'd1,
        S_SODA   = 3'd2,
        S_DIME   = 3'd3,
        S_NICKEL = 3'd4,
        S_GAP    = 3'd5,
        S_FAULT  = 3'd6
    } state_t;

    state_t            r_state;
    state_t            w_next_state;

    logic [2:0]        r_mem [DEPTH];
    logic [c_aw-1:0]   r_wptr;
    logic [c_aw-1:0]   r_rptr;
    logic [c_aw:0]     r_count;
    logic [1:0]        r_dimes;
    logic              r_nickels;
    logic [c_cw-1:0]   r_cnt;
    logic              r_err;
    logic              r_fault;

    logic              w_empty;
    logic              w_full;
    logic              w_pop;
    logic              w_push;
    logic              w_illegal;
    logic [2:0]        w_wdata;
    logic [2:0]        w_head;
    logic              w_req_state;

    assign w_empty     = (r_count == '0);
    assign w_full      = (r_count == c_depth);
    assign w_pop       = (r_state == S_LOAD);
    // A full FIFO still accepts a sale when the engine pops on the same edge.
    assign w_push      = i_soda && (!w_full || w_pop);
    assign w_illegal   = i_soda && (i_change > 3'd4);
    assign w_wdata     = (i_change > 3'd4) ? 3'd0 : i_change;
    assign w_head      = r_mem[r_rptr];
    assign w_req_state = (r_state == S_SODA) || (r_state == S_DIME) ||
                         (r_state == S_NICKEL);

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE:   if (!w_empty) w_next_state = S_LOAD;
            S_LOAD:   w_next_state = S_SODA;
            S_SODA,
            S_DIME,
            S_NICKEL: begin
                if (i_done)
                    w_next_state = S_GAP;
                else if (r_cnt == c_timeout_last)
                    w_next_state = S_FAULT;
            end
            S_GAP: begin
                if (r_cnt == c_gap_last) begin
                    if (r_dimes != 2'd0)
                        w_next_state = S_DIME;
                    else if (r_nickels)
                        w_next_state = S_NICKEL;
                    else if (!w_empty)
                        w_next_state = S_LOAD;
                    else
                        w_next_state = S_IDLE;
                end
            end
            S_FAULT:  w_next_state = S_FAULT;
            default:  w_next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state   <= S_IDLE;
            r_wptr    <= '0;
            r_rptr    <= '0;
            r_count   <= '0;
            r_dimes   <= 2'd0;
            r_nickels <= 1'b0;
            r_cnt     <= '0;
            r_err     <= 1'b0;
            r_fault   <= 1'b0;
        end else begin
            r_state <= w_next_state;

            if (w_push) r_wptr <= r_wptr + c_aw'(1);
            if (w_pop)  r_rptr <= r_rptr + c_aw'(1);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + (c_aw + 1)'(1);
                2'b01:   r_count <= r_count - (c_aw + 1)'(1);
                default: r_count <= r_count;
            endcase

            // One shared counter times both the gap and the request timeout.
            if (w_next_state != r_state)
                r_cnt <= '0;
            else if (w_req_state || (r_state == S_GAP))
                r_cnt <= r_cnt + c_cw'(1);

            if (w_pop) begin
                r_dimes   <= w_head[2:1];
                r_nickels <= w_head[0];
            end else if ((r_state == S_DIME) && i_done) begin
                r_dimes   <= r_dimes - 2'd1;
            end else if ((r_state == S_NICKEL) && i_done) begin
                r_nickels <= 1'b0;
            end

            if ((i_soda && w_full && !w_pop) || w_illegal)
                r_err <= 1'b1;
            if (w_next_state == S_FAULT)
                r_fault <= 1'b1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (w_push) r_mem[r_wptr] <= w_wdata;
    end

    assign o_soda_drop    = (r_state == S_SODA);
    assign o_dime_eject   = (r_state == S_DIME);
    assign o_nickel_eject = (r_state == S_NICKEL);
    assign o_busy         = !w_empty || (r_state != S_IDLE);
    assign o_full         = w_full;
    assign o_err          = r_err;
    assign o_fault        = r_fault;

endmodule
`default_nettype wire
